// File: rtl/skyfi_frame_deframer.sv
// skyfi_frame_deframer: hunts for SYNC, assembles a 4-byte payload and checks
// its trailing CRC-8 (poly 0xD5, init 0x00), with error and statistics outputs.
module skyfi_frame_deframer #(
  parameter logic [7:0] SYNC      = 8'hA5,
  parameter int         TIMEOUT   = 1024,
  parameter bit         CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  input  logic        i_flush,
  output logic [31:0] o_word_out,
  output logic        o_word_valid,
  output logic        o_crc_err,
  output logic        o_timeout_err,
  output logic        o_busy,
  output logic [15:0] o_good_cnt,
  output logic [7:0]  o_err_cnt
);
  localparam int IW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {HUNT, DATA, CRC} state_t;

  state_t        r_state;
  logic [31:0]   r_shift;
  logic [7:0]    r_crc;
  logic [1:0]    r_idx;
  logic [IW-1:0] r_idle;
  logic [7:0]    w_crc_next;
  logic          w_timeout;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int k = 0; k < 8; k++) x = {x[6:0], 1'b0} ^ (x[7] ? 8'hD5 : 8'h00);
    return x;
  endfunction

  assign w_crc_next = crc8_upd(r_crc, i_byte_in);
  // The counter would reach TIMEOUT-1 on this edge; a byte arriving now rescues the frame.
  assign w_timeout  = (r_state != HUNT) && !i_byte_valid && (r_idle == IW'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_shift       <= '0;
      r_crc         <= '0;
      r_idx         <= '0;
      r_idle        <= '0;
      o_word_out    <= '0;
      o_word_valid  <= 1'b0;
      o_crc_err     <= 1'b0;
      o_timeout_err <= 1'b0;
      o_busy        <= 1'b0;
      o_good_cnt    <= '0;
      o_err_cnt     <= '0;
    end else begin
      o_word_valid  <= 1'b0;
      o_crc_err     <= 1'b0;
      o_timeout_err <= 1'b0;
      if (i_flush) begin
        r_state <= HUNT;
        o_busy  <= 1'b0;
        r_idx   <= '0;
        r_idle  <= '0;
        r_crc   <= '0;
      end else if (w_timeout) begin
        r_state       <= HUNT;
        o_busy        <= 1'b0;
        o_timeout_err <= 1'b1;
        if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
      end else begin
        if (r_state != HUNT) r_idle <= i_byte_valid ? '0 : r_idle + IW'(1);
        if (i_byte_valid)
          case (r_state)
            HUNT: if (i_byte_in == SYNC) begin
              r_state <= DATA;
              o_busy  <= 1'b1;
              r_shift <= '0;
              r_crc   <= '0;
              r_idx   <= '0;
              r_idle  <= '0;
            end
            DATA: begin
              r_shift <= {r_shift[23:0], i_byte_in};
              r_crc   <= w_crc_next;
              r_idx   <= r_idx + 2'd1;
              if (r_idx == 2'd3) r_state <= CRC;
            end
            CRC: begin
              r_state <= HUNT;
              o_busy  <= 1'b0;
              if (!CHECK_CRC || i_byte_in == r_crc) begin
                o_word_out   <= r_shift;
                o_word_valid <= 1'b1;
                o_good_cnt   <= o_good_cnt + 16'd1;
              end else begin
                o_crc_err <= 1'b1;
                if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
              end
            end
            default: r_state <= HUNT;
          endcase
      end
    end
  end
endmodule

// File: tb/tb_skyfi_frame_deframer.sv
// tb_skyfi_frame_deframer: directed bench, one checking instance and one with CRC checking off.
module tb_skyfi_frame_deframer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic byte_valid = 1'b0;
  logic flush = 1'b0;
  logic [31:0] wo, nc_wo;
  logic wv, ce, te, busy, nc_wv, nc_ce, nc_te, nc_busy;
  logic [15:0] gc, nc_gc;
  logic [7:0] ec, nc_ec;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skyfi_frame_deframer #(.SYNC(8'hA5), .TIMEOUT(16), .CHECK_CRC(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_byte_in(byte_in), .i_byte_valid(byte_valid), .i_flush(flush),
    .o_word_out(wo), .o_word_valid(wv), .o_crc_err(ce), .o_timeout_err(te), .o_busy(busy),
    .o_good_cnt(gc), .o_err_cnt(ec));

  skyfi_frame_deframer #(.SYNC(8'hA5), .TIMEOUT(16), .CHECK_CRC(1'b0)) u_nc (
    .clk(clk), .rst_n(rst_n), .i_byte_in(byte_in), .i_byte_valid(byte_valid), .i_flush(flush),
    .o_word_out(nc_wo), .o_word_valid(nc_wv), .o_crc_err(nc_ce), .o_timeout_err(nc_te), .o_busy(nc_busy),
    .o_good_cnt(nc_gc), .o_err_cnt(nc_ec));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #22 rst_n = 1'b1;
    tick();
    n_vec++; if (wo !== 32'h0) begin n_err++; $display("FAIL reset word_out: got %h exp 00000000", wo); end
    n_vec++; if ({wv, ce, te, busy} !== 4'b0000) begin n_err++; $display("FAIL reset flags: got %b exp 0000", {wv, ce, te, busy}); end
    n_vec++; if (gc !== 16'h0 || ec !== 8'h0) begin n_err++; $display("FAIL reset counters: got %h/%h exp 0000/00", gc, ec); end
  endtask

  task automatic test_good();
    drive(8'hA5);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL good busy_rise: got %b exp 1", busy); end
    drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h01);
    n_vec++; if (wv !== 1'b0) begin n_err++; $display("FAIL good early_wv: got %b exp 0", wv); end
    drive(8'hD5);
    n_vec++; if (wv !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL good wv_busy: got %b%b exp 10", wv, busy); end
    n_vec++; if (wo !== 32'h00000001) begin n_err++; $display("FAIL good word_out: got %h exp 00000001", wo); end
    n_vec++; if (gc !== 16'd1) begin n_err++; $display("FAIL good good_cnt: got %0d exp 1", gc); end
    tick();
    n_vec++; if (wv !== 1'b0 || wo !== 32'h00000001) begin n_err++; $display("FAIL good pulse_hold: got %b %h exp 0 00000001", wv, wo); end
  endtask

  task automatic test_spaced();
    drive(8'hA5); idle(3); drive(8'h01); idle(3); drive(8'h00); idle(3);
    drive(8'h00); idle(3); drive(8'h00); idle(3); drive(8'h45);
    n_vec++; if (wv !== 1'b1 || wo !== 32'h01000000) begin n_err++; $display("FAIL spaced word: got %b %h exp 1 01000000", wv, wo); end
    n_vec++; if (ce !== 1'b0 || te !== 1'b0 || ec !== 8'd0) begin n_err++; $display("FAIL spaced errs: got %b%b %0d exp 00 0", ce, te, ec); end
    n_vec++; if (gc !== 16'd2) begin n_err++; $display("FAIL spaced good_cnt: got %0d exp 2", gc); end
  endtask

  task automatic test_crc_err();
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h01); drive(8'hD4);
    n_vec++; if (ce !== 1'b1 || wv !== 1'b0) begin n_err++; $display("FAIL crc ce_wv: got %b%b exp 10", ce, wv); end
    n_vec++; if (ec !== 8'd1 || gc !== 16'd2) begin n_err++; $display("FAIL crc counters: got %0d/%0d exp 1/2", ec, gc); end
    n_vec++; if (wo !== 32'h01000000) begin n_err++; $display("FAIL crc word_hold: got %h exp 01000000", wo); end
    n_vec++; if (nc_wv !== 1'b1 || nc_ce !== 1'b0 || nc_wo !== 32'h00000001) begin n_err++; $display("FAIL nocheck accept: got %b%b %h exp 10 00000001", nc_wv, nc_ce, nc_wo); end
  endtask

  task automatic test_hunt();
    drive(8'h11);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hunt garbage1: got %b exp 0", busy); end
    drive(8'h22);
    n_vec++; if (busy !== 1'b0 || ce !== 1'b0) begin n_err++; $display("FAIL hunt garbage2: got %b%b exp 00", busy, ce); end
    drive(8'hA5); drive(8'hA5); drive(8'hA5); drive(8'hA5);
    n_vec++; if (busy !== 1'b1 || wv !== 1'b0) begin n_err++; $display("FAIL hunt no_resync: got %b%b exp 10", busy, wv); end
    drive(8'hA5); drive(8'h05);
    n_vec++; if (wv !== 1'b1 || wo !== 32'hA5A5A5A5) begin n_err++; $display("FAIL hunt word: got %b %h exp 1 a5a5a5a5", wv, wo); end
    n_vec++; if (gc !== 16'd3) begin n_err++; $display("FAIL hunt good_cnt: got %0d exp 3", gc); end
  endtask

  task automatic test_timeout();
    drive(8'hA5); drive(8'h12); idle(14);
    n_vec++; if (te !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL timeout early: got %b%b exp 01", te, busy); end
    idle(1);
    n_vec++; if (te !== 1'b1 || busy !== 1'b0 || ce !== 1'b0) begin n_err++; $display("FAIL timeout fire: got %b%b%b exp 100", te, busy, ce); end
    n_vec++; if (ec !== 8'd2) begin n_err++; $display("FAIL timeout err_cnt: got %0d exp 2", ec); end
    tick();
    n_vec++; if (te !== 1'b0) begin n_err++; $display("FAIL timeout pulse_len: got %b exp 0", te); end
    drive(8'hA5); drive(8'h12); idle(14); drive(8'h34);
    n_vec++; if (te !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL timeout rescued: got %b%b exp 01", te, busy); end
    drive(8'h56); drive(8'h78);
    byte_in = 8'hA5; byte_valid = 1'b1; flush = 1'b1;
    tick();
    byte_valid = 1'b0; flush = 1'b0;
    n_vec++; if ({wv, ce, te, busy} !== 4'b0000 || ec !== 8'd2) begin n_err++; $display("FAIL flush_in_crc: got %b %0d exp 0000 2", {wv, ce, te, busy}, ec); end
  endtask

  task automatic test_flush();
    drive(8'hA5); drive(8'h00);
    byte_in = 8'hA5; byte_valid = 1'b1; flush = 1'b1;
    tick();
    byte_valid = 1'b0; flush = 1'b0;
    n_vec++; if ({wv, ce, te, busy} !== 4'b0000) begin n_err++; $display("FAIL flush state: got %b exp 0000", {wv, ce, te, busy}); end
    drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h01); drive(8'hD5);
    n_vec++; if (wv !== 1'b0 || busy !== 1'b0 || gc !== 16'd3) begin n_err++; $display("FAIL flush byte_dropped: got %b%b %0d exp 00 3", wv, busy, gc); end
    idle(20);
    n_vec++; if (te !== 1'b0 || ec !== 8'd2 || wo !== 32'hA5A5A5A5) begin n_err++; $display("FAIL flush no_side_effects: got %b %0d %h exp 0 2 a5a5a5a5", te, ec, wo); end
  endtask

  task automatic test_back_to_back();
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h01); drive(8'hD5);
    n_vec++; if (wv !== 1'b1 || wo !== 32'h00000001) begin n_err++; $display("FAIL b2b first: got %b %h exp 1 00000001", wv, wo); end
    drive(8'hA5);
    n_vec++; if (busy !== 1'b1 || wv !== 1'b0) begin n_err++; $display("FAIL b2b resync: got %b%b exp 10", busy, wv); end
    drive(8'h01); drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h45);
    n_vec++; if (wv !== 1'b1 || wo !== 32'h01000000 || gc !== 16'd5) begin n_err++; $display("FAIL b2b second: got %b %h %0d exp 1 01000000 5", wv, wo, gc); end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 260; i++) begin
      drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h00); drive(8'h01); drive(8'hD4);
      if (i == 251) begin
        n_vec++; if (ec !== 8'hFE) begin n_err++; $display("FAIL sat pre: got %h exp fe", ec); end
      end
    end
    n_vec++; if (ec !== 8'hFF || ce !== 1'b1) begin n_err++; $display("FAIL sat final: got %h %b exp ff 1", ec, ce); end
    n_vec++; if (gc !== 16'd5 || wo !== 32'h01000000) begin n_err++; $display("FAIL sat untouched: got %0d %h exp 5 01000000", gc, wo); end
  endtask

  task automatic test_async_reset();
    drive(8'hA5); drive(8'h00);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({wv, ce, te, busy} !== 4'b0000 || wo !== 32'h0) begin n_err++; $display("FAIL areset flags: got %b %h exp 0000 00000000", {wv, ce, te, busy}, wo); end
    n_vec++; if (gc !== 16'd0 || ec !== 8'd0) begin n_err++; $display("FAIL areset counters: got %0d %0d exp 0 0", gc, ec); end
    tick();
    rst_n = 1'b1;
    drive(8'h00); drive(8'h00); drive(8'h01); drive(8'hD5);
    n_vec++; if (wv !== 1'b0 || busy !== 1'b0 || gc !== 16'd0) begin n_err++; $display("FAIL areset discard: got %b%b %0d exp 00 0", wv, busy, gc); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_spaced();
    test_crc_err();
    test_hunt();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_err_sat();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/skyfi_frame_deframer.md
# skyfi_frame_deframer

Receive-side application-layer deframer. It consumes the byte stream recovered by the physical layer and hunts for a sync byte. It then assembles the following four payload bytes (MSB first) into a 32-bit word and checks the trailing CRC-8 byte (DVB-S2, poly 0xD5, init 0x00). Good words are presented to the downstream application logic as a one-cycle strobe, and error and statistics outputs are kept for the seven-segment debug display.

## Interface
- SYNC, 8'hA5, frame start byte
- TIMEOUT, 1024, max clk cycles allowed between bytes inside a frame (≥2)
- CHECK_CRC, 1, 1 = enforce CRC match; 0 = accept every frame regardless of CRC byte
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- byte_in  in  8  received byte, qualified by byte_valid
- byte_valid  in  1  one-cycle strobe per received byte
- flush  in  1  synchronous abort to HUNT
- word_out  out  32  last good payload, {D3,D2,D1,D0}
- word_valid  out  1  one-cycle pulse: word_out updated with a good frame
- crc_err  out  1  one-cycle pulse: frame dropped, CRC mismatch
- timeout_err  out  1  one-cycle pulse: frame dropped, inter-byte timeout
- busy  out  1  high whenever state ≠ HUNT
- good_cnt  out  16  good frames received, wraps at 16'hFFFF→0
- err_cnt  out  8  crc_err + timeout_err events, saturates at 8'hFF

## Operation
- Frame layout: SYNC, D3, D2, D1, D0, CRC. CRC = crc8(D3..D0), processed MSB byte first, no reflection, no final XOR.
- Byte-wise CRC update: crc ← T[crc ^ byte], where T is the standard 0xD5 table. A bitwise 8-step equivalent in one cycle is acceptable.
- States and transitions:
  - HUNT: a byte_valid with byte_in == SYNC goes to DATA, clears the shift register, the CRC accumulator (0x00), the byte index (0) and the idle counter. Other bytes are ignored and are not errors.
  - DATA: each byte_valid shifts the byte into the LSB of the 32-bit word, updates the CRC and increments the index. When the 4th byte arrives (index 3), the state goes to CRC. A SYNC value inside DATA is payload; there is no resync.
  - CRC: a byte_valid compares byte_in to the accumulator. On a match or CHECK_CRC=0, word_out is loaded, word_valid pulses and good_cnt increments. On a mismatch, crc_err pulses, err_cnt increments (saturating), and word_out is unchanged. Either outcome returns to HUNT. The CRC byte is never interpreted as a new SYNC.
- Idle counter (DATA/CRC only):
  - Clears on every byte_valid.
  - Otherwise increments.
  - Reaching TIMEOUT-1 with no byte_valid in that cycle causes HUNT, a timeout_err pulse and an err_cnt increment.
- flush (any state) causes HUNT and clears the index, idle counter and CRC. It has priority over byte_valid and timeout. It never pulses the error outputs, and it leaves word_out and the counters unchanged.

## Timing
- Reset values: word_out=0, word_valid=0, crc_err=0, timeout_err=0, busy=0, good_cnt=0, err_cnt=0, state HUNT.
- All outputs are registered.
- Latency: word_valid/crc_err are high in the cycle after the clk edge that samples the CRC byte's byte_valid. word_out is valid in that same cycle and holds until the next good frame.
- busy rises in the cycle after SYNC is sampled and falls in the cycle that word_valid/crc_err/timeout_err is high.
- Back-to-back byte_valid (every cycle) is supported. A SYNC on the cycle immediately after the CRC byte starts the next frame, so there is zero dead time.
- Simultaneity:
  - byte_valid on the would-be timeout cycle: the byte is accepted and there is no timeout.
  - flush with byte_valid: the byte is dropped.
- The error pulses are mutually exclusive, and at most one of word_valid/crc_err/timeout_err is high per cycle.
- Reset asserted mid-frame returns immediately to HUNT with all outputs at reset values. The partial frame is discarded.

## Test plan
- Good frame: bytes A5,00,00,00,01,D5 on consecutive cycles → word_valid pulse 1 cycle after D5, word_out=32'h00000001, good_cnt=1, busy low same cycle.
- Good frame spaced by 3 idle cycles: A5,01,00,00,00,45 → word_out=32'h01000000, no errors.
- CRC mismatch: A5,00,00,00,01,D4 → crc_err pulse, err_cnt=1, word_out keeps the previous value. Repeat with CHECK_CRC=0 → word_valid, word_out=32'h00000001.
- Hunt/no-resync:
  - 11,22,A5 as preamble garbage followed by A5,A5,A5,A5,crc(A5A5A5A5) → garbage ignored, a single word_valid, word_out=32'hA5A5A5A5.
- Timeout: TIMEOUT=16, send A5,12 then idle → timeout_err pulses on the cycle the idle counter reaches 15, busy drops. Then send a byte on exactly cycle TIMEOUT-1 in a second frame → no timeout.
- flush mid-frame after A5,00 with byte_valid in the same cycle → HUNT, no error pulses. err_cnt saturation: 260 bad frames → err_cnt=8'hFF. Async reset mid-frame → all outputs 0.
